uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
Parametrised second-generation UART receive controller. It owns the oversampling edge counter, the bit counter, majority-vote sampling, start/parity/stop checking and data deserialisation. It adds configurable data width, odd/even parity, one or two stop bits, and break detection. It takes the synchronised serial line and delivers one-cycle validated frames to the downstream byte consumer.

Parameters:
DATA_WIDTH, 8, data bits per frame, legal 5..9
PRESCALE_W, 6, width of prescale input and edge counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
rx_in  in  1  serial line, already synchronised to clock, idle high
prescale  in  PRESCALE_W  oversampling ratio per bit; LSB ignored; values below 8 treated as 8
parity_en  in  1  parity bit present
parity_odd  in  1  1 = odd parity, 0 = even parity
stop_two  in  1  1 = two stop bits
data_out  out  DATA_WIDTH  last good frame, LSB received first
data_valid  out  1  one-cycle pulse: data_out holds a new good frame
parity_error  out  1  one-cycle pulse: parity mismatch
framing_error  out  1  one-cycle pulse: a stop bit sampled low (not break)
break_detect  out  1  one-cycle pulse: break condition
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, shift register 0. Reset mid-frame aborts the frame with no pulses.
- Configuration latch: prescale (clamped, LSB cleared), parity_en, parity_odd and stop_two are registered on the IDLE->START transition and held for the frame. Changes mid-frame have no effect.
- Timing terms: p = latched prescale; mid = p>>1. edge_cnt counts 0..p-1 and wraps to 0 on every bit boundary.
- Sampling: rx_in is sampled at edge_cnt = mid-1, mid and mid+1. The majority bit is registered and valid while edge_cnt = mid+2, called the decision edge.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, BRK_WAIT.
- IDLE: rx_in==0 -> START with edge_cnt=0 next cycle.
- START: decision edge with voted=1 -> IDLE (glitch; no pulses). At edge_cnt=p-1 -> DATA with bit_cnt=0.
- DATA: at the decision edge, shift the voted bit in (LSB-first, right shift). At edge_cnt=p-1: if bit_cnt==DATA_WIDTH-1, go to PARITY if parity_en, else STOP1; otherwise bit_cnt+1.
- PARITY: at the decision edge, perr = (^shift ^ voted) ^ parity_odd. At edge_cnt=p-1 -> STOP1.
- STOP1: at the decision edge, record stop1. If stop_two, continue to edge_cnt=p-1 -> STOP2. Otherwise go to DONE on the cycle after the decision edge. There is no wait to end of bit; this gives half-bit margin for resync.
- STOP2: at the decision edge, record stop2 -> DONE.
- Break: all data bits 0, the parity bit 0 (if enabled), and any stop bit 0.
- DONE (exactly one cycle); outputs are registered and high during the DONE cycle:
  - break: break_detect=1 only (no framing_error, no data_valid); next state BRK_WAIT.
  - otherwise: framing_error = any stop 0; parity_error = parity_en & perr; data_valid = neither error. data_out loads the shift register only when data_valid.
  - next state: rx_in==0 -> START (back-to-back frame), else IDLE.
- BRK_WAIT: stay until rx_in==1 -> IDLE. No pulses.
- Latency: the pulse cycle, counted from the IDLE cycle seeing rx_in low as cycle 0, is 1 + p*L + mid + 3. L = index of the last stop bit, with the start bit as index 0.
- Widths: bit_cnt is $clog2(DATA_WIDTH+1) bits. Compare p-1 at PRESCALE_W bits with no overflow, since p >= 8.

Decomposition:
- Shared package uart_pkg: state enum (gray-coded), DATA_WIDTH limits, MIN_PRESCALE=8.
- Sub-module uart_rx_majority_sampler: inputs rx_in, edge_cnt, mid; output registered voted bit valid at mid+2.

Test Plan:
- DW=8, p=8, no parity, 1 stop, send 0xA5 -> data_valid pulse at cycle 80, data_out=0xA5, no error pulses.
- DW=7, p=16, odd parity, 2 stops, send 0x35 with parity 1 -> data_valid, data_out=0x35. Repeat with parity 0 -> parity_error only, data_out unchanged.
- rx_in low for 3 cycles only, p=8 -> returns to IDLE within 7 cycles, busy drops, no pulses.
- Stop bit forced low with data 0x3C -> framing_error pulse, data_valid 0. Line low for 20 bit times -> one break_detect, BRK_WAIT until rx_in high.
- Two frames 0x11 and 0xEE back-to-back with no idle -> two data_valid pulses, second frame received correctly via the DONE->START path.
- Assert reset during DATA bit 4 -> all outputs 0 immediately; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame controller: FSM state encoding,
// data-width limits and the minimum oversampling ratio.
package uart_pkg;

   localparam int unsigned DATA_WIDTH_MIN = 5;
   localparam int unsigned DATA_WIDTH_MAX = 9;
   localparam int unsigned MIN_PRESCALE   = 8;

   // Gray-coded along the normal frame path so neighbouring states differ in one bit.
   typedef enum logic [2:0] {
      StIdle    = 3'b000,
      StStart   = 3'b001,
      StData    = 3'b011,
      StParity  = 3'b010,
      StStop1   = 3'b110,
      StStop2   = 3'b111,
      StDone    = 3'b101,
      StBrkWait = 3'b100
   } uart_rx_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_majority_sampler.sv
// Three-point majority vote around the bit centre; the voted bit is registered
// and valid while edge_cnt_i equals mid_i + 2.
module uart_rx_majority_sampler
   import uart_pkg::*;
#(
   parameter int unsigned PRESCALE_W = 6
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rx_in_i,
   input  logic [PRESCALE_W-1:0] edge_cnt_i,
   input  logic [PRESCALE_W-1:0] mid_i,
   output logic                  voted_o
);

   logic s0_q;
   logic s1_q;
   logic voted_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s0_q    <= 1'b0;
         s1_q    <= 1'b0;
         voted_q <= 1'b0;
      end else begin
         if (edge_cnt_i == mid_i - PRESCALE_W'(1)) begin
            s0_q <= rx_in_i;
         end
         if (edge_cnt_i == mid_i) begin
            s1_q <= rx_in_i;
         end
         // Third sample is taken live and folded straight into the vote.
         if (edge_cnt_i == mid_i + PRESCALE_W'(1)) begin
            voted_q <= maj3(s0_q, s1_q, rx_in_i);
         end
      end
   end

   assign voted_o = voted_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: oversampled start/data/parity/stop handling,
// break detection and one-cycle validated frame delivery.
module uart_rx_frame_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESCALE_W = 6
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  parity_en,
   input  logic                  parity_odd,
   input  logic                  stop_two,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  parity_error,
   output logic                  framing_error,
   output logic                  break_detect,
   output logic                  busy
);

   localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);

   if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
      $error("uart_rx_frame_ctrl: DATA_WIDTH out of range");
   end

   uart_rx_state_e        state_q;
   logic [PRESCALE_W-1:0] edge_cnt_q;
   logic [BCW-1:0]        bit_cnt_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [PRESCALE_W-1:0] p_last_q;
   logic [PRESCALE_W-1:0] mid_q;
   logic                  par_en_q;
   logic                  par_odd_q;
   logic                  stop_two_q;
   logic                  perr_q;
   logic                  par_bit_q;
   logic                  stop1_q;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic                  data_valid_q;
   logic                  parity_error_q;
   logic                  framing_error_q;
   logic                  break_q;

   logic                  voted;
   logic [PRESCALE_W-1:0] p_even;
   logic [PRESCALE_W-1:0] p_clamp;
   logic [PRESCALE_W-1:0] edge_next;
   logic                  dec_edge;
   logic                  last_edge;
   logic                  stops_ok;
   logic                  is_break;

   uart_rx_majority_sampler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_sampler (
      .clock      (clock),
      .reset      (reset),
      .rx_in_i    (rx_in),
      .edge_cnt_i (edge_cnt_q),
      .mid_i      (mid_q),
      .voted_o    (voted)
   );

   always_comb begin
      p_even    = prescale & ~PRESCALE_W'(1);
      p_clamp   = (p_even < PRESCALE_W'(MIN_PRESCALE)) ? PRESCALE_W'(MIN_PRESCALE) : p_even;
      dec_edge  = (edge_cnt_q == mid_q + PRESCALE_W'(2));
      last_edge = (edge_cnt_q == p_last_q);
      edge_next = last_edge ? '0 : edge_cnt_q + 1'b1;
      // In STOP2 the first stop was recorded earlier; otherwise the vote is the only stop.
      stops_ok  = (state_q == StStop2) ? (stop1_q & voted) : voted;
      is_break  = (shift_q == '0) && (!par_en_q || !par_bit_q) && !stops_ok;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= StIdle;
         edge_cnt_q      <= '0;
         bit_cnt_q       <= '0;
         shift_q         <= '0;
         p_last_q        <= '0;
         mid_q           <= '0;
         par_en_q        <= 1'b0;
         par_odd_q       <= 1'b0;
         stop_two_q      <= 1'b0;
         perr_q          <= 1'b0;
         par_bit_q       <= 1'b0;
         stop1_q         <= 1'b0;
         data_out_q      <= '0;
         data_valid_q    <= 1'b0;
         parity_error_q  <= 1'b0;
         framing_error_q <= 1'b0;
         break_q         <= 1'b0;
      end else begin
         data_valid_q    <= 1'b0;
         parity_error_q  <= 1'b0;
         framing_error_q <= 1'b0;
         break_q         <= 1'b0;
         edge_cnt_q      <= edge_next;

         unique case (state_q)
            StIdle: begin
               edge_cnt_q <= '0;
               if (!rx_in) begin
                  state_q    <= StStart;
                  p_last_q   <= p_clamp - 1'b1;
                  mid_q      <= p_clamp >> 1;
                  par_en_q   <= parity_en;
                  par_odd_q  <= parity_odd;
                  stop_two_q <= stop_two;
               end
            end
            StStart: begin
               if (dec_edge && voted) begin
                  state_q    <= StIdle;
                  edge_cnt_q <= '0;
               end else if (last_edge) begin
                  state_q   <= StData;
                  bit_cnt_q <= '0;
               end
            end
            StData: begin
               if (dec_edge) begin
                  shift_q <= {voted, shift_q[DATA_WIDTH-1:1]};
               end
               if (last_edge) begin
                  if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                     state_q <= par_en_q ? StParity : StStop1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end
            StParity: begin
               if (dec_edge) begin
                  perr_q    <= (^shift_q ^ voted) ^ par_odd_q;
                  par_bit_q <= voted;
               end
               if (last_edge) begin
                  state_q <= StStop1;
               end
            end
            StStop1, StStop2: begin
               if (dec_edge && (state_q == StStop1)) begin
                  stop1_q <= voted;
               end
               // Frame closes on the final stop's decision edge, half a bit early for resync.
               if (dec_edge && ((state_q == StStop2) || !stop_two_q)) begin
                  state_q    <= StDone;
                  edge_cnt_q <= '0;
                  if (is_break) begin
                     break_q <= 1'b1;
                  end else begin
                     framing_error_q <= !stops_ok;
                     parity_error_q  <= par_en_q & perr_q;
                     if (stops_ok && !(par_en_q && perr_q)) begin
                        data_valid_q <= 1'b1;
                        data_out_q   <= shift_q;
                     end
                  end
               end else if (last_edge && (state_q == StStop1)) begin
                  state_q <= StStop2;
               end
            end
            StDone: begin
               edge_cnt_q <= '0;
               if (break_q) begin
                  state_q <= StBrkWait;
               end else begin
                  state_q <= rx_in ? StIdle : StStart;
               end
            end
            StBrkWait: begin
               edge_cnt_q <= '0;
               if (rx_in) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q    <= StIdle;
               edge_cnt_q <= '0;
            end
         endcase
      end
   end

   assign data_out      = data_out_q;
   assign data_valid    = data_valid_q;
   assign parity_error  = parity_error_q;
   assign framing_error = framing_error_q;
   assign break_detect  = break_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: an 8-bit and a 7-bit instance driven
// by a bit-level serial sender, pulses matched against queued expectations.
module tb_uart_rx_frame_ctrl;

   typedef struct packed {
      logic [3:0] flags;  // {data_valid, parity_error, framing_error, break_detect}
      logic [8:0] data;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx8 = 1'b1;
   logic       rx7 = 1'b1;
   logic [5:0] prescale = 6'd8;
   logic       parity_en = 1'b0;
   logic       parity_odd = 1'b0;
   logic       stop_two = 1'b0;

   logic [7:0] data8;
   logic       dv8, pe8, fe8, bd8, busy8;
   logic [6:0] data7;
   logic       dv7, pe7, fe7, bd7, busy7;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   pulse8_cnt = 0;
   int   pulse8_cyc = 0;
   int   pulse7_cnt = 0;
   int   pulse7_cyc = 0;
   logic [7:0] last_good8 = 8'h00;
   exp_t exp8[$];
   exp_t exp7[$];

   uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
      .clock(clock), .reset(reset), .rx_in(rx8), .prescale(prescale),
      .parity_en(parity_en), .parity_odd(parity_odd), .stop_two(stop_two),
      .data_out(data8), .data_valid(dv8), .parity_error(pe8),
      .framing_error(fe8), .break_detect(bd8), .busy(busy8)
   );

   uart_rx_frame_ctrl #(.DATA_WIDTH(7), .PRESCALE_W(6)) dut7 (
      .clock(clock), .reset(reset), .rx_in(rx7), .prescale(prescale),
      .parity_en(parity_en), .parity_odd(parity_odd), .stop_two(stop_two),
      .data_out(data7), .data_valid(dv7), .parity_error(pe7),
      .framing_error(fe7), .break_detect(bd7), .busy(busy7)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      logic [3:0] f;
      exp_t       e;
      f = {dv8, pe8, fe8, bd8};
      if (!reset && ((|f) !== 1'b0)) begin
         pulse8_cnt++;
         pulse8_cyc = cyc;
         checks++;
         if (exp8.size() == 0) begin
            errors++;
            $display("FAIL sb8_unexpected: flags=%b data=%h, none expected", f, data8);
         end else begin
            e = exp8.pop_front();
            if (f !== e.flags || data8 !== e.data[7:0]) begin
               errors++;
               $display("FAIL sb8_frame: flags=%b data=%h, expected flags=%b data=%h",
                        f, data8, e.flags, e.data[7:0]);
            end
         end
      end
   end

   always @(negedge clock) begin
      logic [3:0] f;
      exp_t       e;
      f = {dv7, pe7, fe7, bd7};
      if (!reset && ((|f) !== 1'b0)) begin
         pulse7_cnt++;
         pulse7_cyc = cyc;
         checks++;
         if (exp7.size() == 0) begin
            errors++;
            $display("FAIL sb7_unexpected: flags=%b data=%h, none expected", f, data7);
         end else begin
            e = exp7.pop_front();
            if (f !== e.flags || data7 !== e.data[6:0]) begin
               errors++;
               $display("FAIL sb7_frame: flags=%b data=%h, expected flags=%b data=%h",
                        f, data7, e.flags, e.data[6:0]);
            end
         end
      end
   end

   // Caller must be aligned just after a rising edge; each bit lasts p cycles.
   task automatic send_frame(input bit sel7, input logic [8:0] data, input int nbits,
                             input bit with_par, input bit par_bit, input bit stop_val,
                             input int nstops, input int p);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
      if (with_par) bits.push_back(par_bit);
      for (int i = 0; i < nstops; i++) bits.push_back(stop_val);
      foreach (bits[i]) begin
         if (sel7) rx7 = bits[i];
         else rx8 = bits[i];
         repeat (p) @(posedge clock);
         #1;
      end
      if (sel7) rx7 = 1'b1;
      else rx8 = 1'b1;
   endtask

   task automatic wait_pulse(input bit sel7, input int target, input int budget,
                             output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if ((sel7 ? pulse7_cnt : pulse8_cnt) >= target) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
         #1;
      end
   endtask

   task automatic test_reset;
      #3;
      checks++;
      if ({data8, dv8, pe8, fe8, bd8, busy8} !== 13'd0 ||
          {data7, dv7, pe7, fe7, bd7, busy7} !== 12'd0) begin
         errors++;
         $display("FAIL reset_outputs: dut8=%h/%b%b%b%b%b dut7=%h/%b%b%b%b%b, expected all 0",
                  data8, dv8, pe8, fe8, bd8, busy8, data7, dv7, pe7, fe7, bd7, busy7);
      end
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      checks++;
      if (busy8 !== 1'b0 || busy7 !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy8=%b busy7=%b, expected 0 0", busy8, busy7);
      end
   endtask

   task automatic test_basic;
      int t0;
      bit ok;
      int base;
      prescale = 6'd8; parity_en = 1'b0; parity_odd = 1'b0; stop_two = 1'b0;
      base = pulse8_cnt;
      exp8.push_back('{flags: 4'b1000, data: 9'h0A5});
      last_good8 = 8'hA5;
      @(posedge clock); #1;
      t0 = cyc;
      fork
         send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1, 8);
         begin
            // Mid-frame configuration change must be ignored.
            repeat (30) @(posedge clock);
            #1 prescale = 6'd20; parity_en = 1'b1; stop_two = 1'b1;
         end
      join
      wait_pulse(1'b0, base + 1, 40, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL basic_timeout: pulses=%0d, expected %0d", pulse8_cnt, base + 1);
      end
      checks++;
      if (pulse8_cyc - t0 != 80) begin
         errors++;
         $display("FAIL basic_latency: %0d cycles, expected 80", pulse8_cyc - t0);
      end
      prescale = 6'd8; parity_en = 1'b0; stop_two = 1'b0;
   endtask

   task automatic test_parity;
      int t0;
      bit ok;
      int base;
      prescale = 6'd16; parity_en = 1'b1; parity_odd = 1'b1; stop_two = 1'b1;
      base = pulse7_cnt;
      exp7.push_back('{flags: 4'b1000, data: 9'h035});
      @(posedge clock); #1;
      t0 = cyc;
      send_frame(1'b1, 9'h035, 7, 1'b1, 1'b1, 1'b1, 2, 16);
      wait_pulse(1'b1, base + 1, 40, ok);
      checks++;
      if (!ok || pulse7_cyc - t0 != 172) begin
         errors++;
         $display("FAIL parity_good_latency: ok=%0d cycles=%0d, expected 1 172",
                  ok, pulse7_cyc - t0);
      end
      exp7.push_back('{flags: 4'b0100, data: 9'h035});
      repeat (4) @(posedge clock); #1;
      send_frame(1'b1, 9'h035, 7, 1'b1, 1'b0, 1'b1, 2, 16);
      wait_pulse(1'b1, base + 2, 40, ok);
      checks++;
      if (!ok || exp7.size() != 0) begin
         errors++;
         $display("FAIL parity_bad: ok=%0d pending=%0d, expected 1 0", ok, exp7.size());
      end
      parity_en = 1'b0; parity_odd = 1'b0; stop_two = 1'b0; prescale = 6'd8;
   endtask

   task automatic test_glitch;
      int n;
      prescale = 6'd8;
      @(posedge clock); #1;
      rx8 = 1'b0;
      repeat (3) @(posedge clock);
      #1 rx8 = 1'b1;
      checks++;
      if (busy8 !== 1'b1) begin
         errors++;
         $display("FAIL glitch_busy: busy=%b, expected 1", busy8);
      end
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clock); #1;
         n = i;
         if (busy8 === 1'b0) break;
      end
      checks++;
      if (busy8 !== 1'b0 || n > 7) begin
         errors++;
         $display("FAIL glitch_idle: busy=%b after %0d cycles, expected 0 within 7", busy8, n);
      end
   endtask

   task automatic test_framing_break;
      bit ok;
      int base;
      prescale = 6'd8;
      base = pulse8_cnt;
      exp8.push_back('{flags: 4'b0010, data: {1'b0, last_good8}});
      @(posedge clock); #1;
      send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1, 8);
      wait_pulse(1'b0, base + 1, 40, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL framing_timeout: pulses=%0d, expected %0d", pulse8_cnt, base + 1);
      end
      exp8.push_back('{flags: 4'b0001, data: {1'b0, last_good8}});
      repeat (4) @(posedge clock); #1;
      rx8 = 1'b0;
      repeat (160) @(posedge clock);
      #1;
      checks++;
      if (pulse8_cnt != base + 2 || busy8 !== 1'b1) begin
         errors++;
         $display("FAIL break_wait: pulses=%0d busy=%b, expected %0d 1",
                  pulse8_cnt, busy8, base + 2);
      end
      rx8 = 1'b1;
      repeat (2) @(posedge clock); #1;
      checks++;
      if (busy8 !== 1'b0) begin
         errors++;
         $display("FAIL break_release: busy=%b, expected 0", busy8);
      end
   endtask

   task automatic test_back_to_back;
      int t0;
      bit ok;
      int base;
      prescale = 6'd9;  // odd value behaves as 8
      base = pulse8_cnt;
      exp8.push_back('{flags: 4'b1000, data: 9'h011});
      exp8.push_back('{flags: 4'b1000, data: 9'h0EE});
      last_good8 = 8'hEE;
      @(posedge clock); #1;
      t0 = cyc;
      send_frame(1'b0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1, 8);
      send_frame(1'b0, 9'h0EE, 8, 1'b0, 1'b0, 1'b1, 1, 8);
      wait_pulse(1'b0, base + 2, 40, ok);
      checks++;
      if (!ok || pulse8_cyc - t0 != 160) begin
         errors++;
         $display("FAIL b2b_second: ok=%0d cycles=%0d, expected 1 160", ok, pulse8_cyc - t0);
      end
   endtask

   task automatic test_reset_midframe;
      bit ok;
      int base;
      prescale = 6'd4;  // below minimum, behaves as 8
      @(posedge clock); #1;
      rx8 = 1'b0;
      repeat (44) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({data8, dv8, pe8, fe8, bd8, busy8} !== 13'd0) begin
         errors++;
         $display("FAIL midframe_reset: data=%h flags=%b%b%b%b busy=%b, expected all 0",
                  data8, dv8, pe8, fe8, bd8, busy8);
      end
      @(posedge clock); #1;
      rx8 = 1'b1;
      reset = 1'b0;
      last_good8 = 8'h00;
      repeat (3) @(posedge clock); #1;
      base = pulse8_cnt;
      exp8.push_back('{flags: 4'b1000, data: 9'h0C3});
      last_good8 = 8'hC3;
      send_frame(1'b0, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1, 8);
      wait_pulse(1'b0, base + 1, 40, ok);
      checks++;
      if (!ok || exp8.size() != 0) begin
         errors++;
         $display("FAIL midframe_recover: ok=%0d pending=%0d, expected 1 0", ok, exp8.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_glitch();
      test_framing_break();
      test_back_to_back();
      test_reset_midframe();
      repeat (20) @(posedge clock); #1;
      checks++;
      if (exp8.size() != 0 || exp7.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: pending8=%0d pending7=%0d, expected 0 0",
                  exp8.size(), exp7.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 1 ms");
      $fatal(1, "watchdog");
   end

endmodule
